// File: rtl/add_arb_pkg.sv
// Shared types, constants and the round-robin pick function for add_arbiter.
// Optional output-register build is selected with ADD_ARB_OUTREG_EN.
package add_arb_pkg;

  localparam int ADD_W   = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } add_arb_state_t;

  // One-hot pick of the first asserted valid at or after ptr, wrapping at nreq.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 nreq
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [2:0]         idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % nreq);
      if ((k < nreq) && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/add.sv
// Block carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Carry out is dropped, so the sum wraps modulo 2^W.
module Add
  import add_arb_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   carry;
  logic         unused_cout;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    carry = '0;
    for (int j = 0; j < W / 4; j++) begin
      carry[4*j+1] = g[4*j] | (p[4*j] & carry[4*j]);
      carry[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                   | (p[4*j+1] & p[4*j] & carry[4*j]);
      carry[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                   | (p[4*j+2] & p[4*j+1] & g[4*j])
                   | (p[4*j+2] & p[4*j+1] & p[4*j] & carry[4*j]);
      carry[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                   | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                   | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                   | ((&p[4*j +: 4]) & carry[4*j]);
    end
  end

  assign sum         = p ^ carry[W-1:0];
  assign unused_cout = carry[W];

endmodule

// File: rtl/add_arbiter_rr_arbiter.sv
// Round-robin arbiter: priority pointer register plus one-hot pick.
// The pointer moves to winner+1 (wrapping) only when a grant is taken.
module rr_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic            advance,
  output logic [IW-1:0]   winner_idx
);

  logic [IW-1:0]      ptr;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  assign valid_ext   = MAX_REQ'(valid);
  assign pick        = rr_pick(valid_ext, 3'(ptr), NREQ);
  assign unused_pick = ^pick;

  assign grant   = enable ? pick[NREQ-1:0] : '0;
  assign advance = |(grant & valid);

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) winner_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner_idx == IW'(NREQ - 1)) ? '0 : winner_idx + 1'b1;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Shares one adder among NREQ requesters; one operation in flight at a time.
// Define ADD_ARB_OUTREG_EN to register the sum (adds the EXEC state).
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic                  busy
);

`ifdef ADD_ARB_OUTREG_EN
  localparam add_arb_state_t AFTER_GRANT = EXEC;
`else
  localparam add_arb_state_t AFTER_GRANT = RESP;
`endif

  add_arb_state_t state;
  add_arb_state_t state_nxt;
  logic [ADD_W-1:0] op_a;
  logic [ADD_W-1:0] op_b;
  logic [ADD_W-1:0] sel_a;
  logic [ADD_W-1:0] sel_b;
  logic [ADD_W-1:0] add_out;
  logic [IW-1:0]    id_q;
  logic [IW-1:0]    winner_idx;
  logic             advance;

  // Grants are only offered in IDLE, so nothing is granted while a result waits.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (state == IDLE),
    .valid      (req_valid),
    .grant      (req_ready),
    .advance    (advance),
    .winner_idx (winner_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_a = req_a[i*ADD_W +: ADD_W];
        sel_b = req_b[i*ADD_W +: ADD_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (advance) state_nxt = AFTER_GRANT;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id_q <= winner_idx;
      end
    end
  end

  Add #(.W(ADD_W)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_out)
  );

`ifdef ADD_ARB_OUTREG_EN
  logic [ADD_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (state == EXEC) begin
      sum_q <= add_out;
    end
  end

  assign rsp_sum = sum_q;
`else
  assign rsp_sum = (state == RESP) ? add_out : '0;
`endif

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: vector table plus multi-cycle sequences.
// Works in either build; latency expectations follow ADD_ARB_OUTREG_EN.
module tb_add_arbiter;

  localparam int NREQ = 4;
`ifdef ADD_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [31:0]          rsp_sum;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  add_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One complete operation with rsp_ready held high; the granted requester drops.
  task automatic run_op(input logic [3:0] valid, input logic [3:0] exp_grant,
                        input int exp_id, input logic [31:0] exp_sum, input string name);
    int cyc;
    req_valid = valid;
    rsp_ready = 1'b1;
    #1 check({name, "_grant"}, 32'(req_ready), 32'(exp_grant));
    step();
    req_valid = valid & ~exp_grant;
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check({name, "_latency"}, cyc, LAT);
    check({name, "_id"}, 32'(rsp_id), exp_id);
    check({name, "_sum"}, rsp_sum, exp_sum);
    step();
    req_valid = '0;
    check({name, "_valid_after"}, 32'(rsp_valid), 0);
    check({name, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   cyc;
    int   got;
    int   last;

    vecs[0] = '{0, 32'd5,          32'd7,          32'd12};
    vecs[1] = '{2, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    vecs[2] = '{3, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000};
    vecs[3] = '{1, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789};
    vecs[4] = '{0, 32'h0000_FFFF,  32'd1,          32'h0001_0000};
    vecs[5] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[6] = '{1, 32'h0F0F_0F0F,  32'hF0F0_F0F0,  32'hFFFF_FFFF};

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #3;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id",    32'(rsp_id),    0);
    check("rst_rsp_sum",   rsp_sum,        0);
    check("rst_busy",      32'(busy),      0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_no_req_ready", 32'(req_ready), 0);

    // Single-requester vectors: grant is independent of the pointer.
    for (int i = 0; i < 7; i++) begin
      set_ops(vecs[i].r, vecs[i].a, vecs[i].b);
      run_op(4'(1 << vecs[i].r), 4'(1 << vecs[i].r), vecs[i].r, vecs[i].sum,
             $sformatf("vec%0d", i));
    end

    // All requesters continuously valid from reset: ids 0,1,2,3,0.
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i), 32'd100);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1 check("all_first_grant", 32'(req_ready), 32'h1);
    got  = 0;
    cyc  = 0;
    last = 0;
    while (got < 5 && cyc < 60) begin
      step();
      cyc++;
      if (rsp_valid) begin
        check($sformatf("all_id%0d", got),  32'(rsp_id), got % 4);
        check($sformatf("all_sum%0d", got), rsp_sum,     32'(100 + got % 4));
        if (got > 0) check($sformatf("all_gap%0d", got), cyc - last, LAT + 1);
        last = cyc;
        got++;
        if (got == 5) req_valid = '0;
      end
    end
    check("all_count", got, 5);
    step();
    check("all_idle", 32'(busy), 0);

    // Fairness: after req1, search starts at 2, so req3 beats req0; then req0.
    reset_dut();
    set_ops(1, 32'd1, 32'd1);
    run_op(4'b0010, 4'b0010, 1, 32'd2, "fair_r1");
    set_ops(0, 32'd40, 32'd2);
    set_ops(3, 32'd30, 32'd3);
    run_op(4'b1001, 4'b1000, 3, 32'd33, "fair_r3");
    run_op(4'b1001, 4'b0001, 0, 32'd42, "fair_r0");

    // Backpressure: response held 5 cycles while req0 waits.
    set_ops(2, 32'd10, 32'd20);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1 check("bp_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0001;
    set_ops(0, 32'd1, 32'd2);
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check("bp_latency", cyc, LAT);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 1);
      check($sformatf("bp_id%0d", i),    32'(rsp_id),    2);
      check($sformatf("bp_sum%0d", i),   rsp_sum,        32'd30);
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    #1 check("bp_no_grant_on_accept", 32'(req_ready), 0);
    step();
    check("bp_accepted", 32'(rsp_valid), 0);
    check("bp_idle_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    rsp_ready = 1'b0;
    #1 check("bp_drop_before_grant", 32'(req_ready), 0);
    step();
    check("bp_no_handshake", 32'(busy), 0);

    // Reset mid-operation discards the operation and clears the pointer.
    set_ops(2, 32'd7, 32'd8);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy",  32'(busy),      0);
    check("mid_rst_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_no_rsp", 32'(rsp_valid), 0);
    set_ops(1, 32'h100, 32'h23);
    set_ops(3, 32'h200, 32'h45);
    run_op(4'b1010, 4'b0010, 1, 32'h123, "mid_r1");
    run_op(4'b1010, 4'b1000, 3, 32'h245, "mid_r3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit carry-lookahead adder (`Add`) among `NREQ` requesters. Each requester submits an operand pair over a valid/ready handshake. The block grants one requester at a time, drives the shared adder from registered operands, and returns the 32-bit sum with the requester ID over a single backpressured response channel. It sits between client engines and the adder datapath; only one operation is ever in flight.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester operation request.
- `req_ready`  out  NREQ  one-hot grant; a handshake is `req_valid[i] & req_ready[i]`.
- `req_a`  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- `req_b`  in  NREQ*32  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the result.
- `rsp_sum`  out  32  `(a + b) mod 2^32`; no carry out.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC (present only with `ADD_ARB_OUTREG_EN`), RESP.
- IDLE:
  - `req_ready` is the one-hot round-robin pick among asserted `req_valid`; it is combinational from `req_valid` and the priority pointer.
  - `req_ready` is all-zero when no request is valid.
- On a handshake:
  - capture `req_a`/`req_b` of the winner into `op_a`/`op_b`, and its index into `id_q`;
  - advance the pointer to winner+1, wrapping at NREQ;
  - go to EXEC, or to RESP when the macro is off.
- EXEC: register the `Add` output of `op_a`/`op_b` into `sum_q`, then go to RESP.
- RESP:
  - `rsp_valid`=1, `rsp_id`=`id_q`, `rsp_sum` as described under Configuration;
  - hold all outputs stable until `rsp_ready`;
  - on `rsp_valid & rsp_ready`, go to IDLE.
- `req_ready` is 0 in every state other than IDLE. No new grant occurs in the cycle a response is accepted.
- Round-robin:
  - the search starts at the pointer and wraps;
  - after reset the pointer is 0, so requester 0 has the highest priority;
  - a requester that is continuously valid is granted at least once every NREQ operations.
- Overflow wraps silently: `0xFFFFFFFF + 1` returns `0`.
- Dropping `req_valid` before a grant is legal and has no effect.

## Timing
- Reset values: state=IDLE, pointer=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `busy`=0, `op_a`/`op_b`/`sum_q`=0.
- Reset mid-operation discards any in-flight operation. No response is produced for it.
- Latency from handshake edge to first `rsp_valid` cycle: 2 cycles with the macro, 1 cycle without.
- Throughput with `rsp_ready` tied high: one operation per 3 cycles with the macro, one per 2 cycles without.
- Simultaneous `req_valid` on all requesters: grants go 0,1,2,3,0,… from reset.
- `rsp_ready` asserted before `rsp_valid` has no effect.

## Configuration
- `ADD_ARB_OUTREG_EN` defined:
  - the EXEC state exists;
  - `rsp_sum` is driven from register `sum_q`, so the adder path ends at a flop (timing-friendly).
- `ADD_ARB_OUTREG_EN` undefined:
  - there is no EXEC state and no `sum_q`;
  - `rsp_sum` is driven combinationally by `Add(op_a, op_b)` during RESP, saving one cycle.
- Port list and handshake rules are identical in both builds.

## Structure
- Package `add_arb_pkg`:
  - state enum `add_arb_state_t` (IDLE, EXEC, RESP);
  - constant `ADD_W`=32;
  - function `rr_pick(valid, ptr)` returning the one-hot grant.
- Sub-module `rr_arbiter`: pointer register plus one-hot pick, with `advance` and `winner_idx` outputs. It is instantiated once.
- The shared `Add` is instantiated once inside `add_arbiter`.

## Test plan
- Single request: req0 a=5, b=7, `rsp_ready`=1 → `rsp_valid` 2 cycles after the handshake (1 cycle without the macro), `rsp_id`=0, `rsp_sum`=12.
- Wrap: a=0xFFFFFFFF, b=1 on req2 → `rsp_sum`=0x00000000, `rsp_id`=2.
- All four requesters valid continuously with distinct operands (req i: a=i, b=100) → `rsp_id` order 0,1,2,3,0 and sums 100,101,102,103,100.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_id`, `rsp_sum` stable and `req_ready`=0 throughout; one response is accepted when `rsp_ready` rises.
- Fairness after a grant: req1 granted, then req0 and req3 both valid → req3 is granted next (search starts at 2).
- Reset mid-operation: deassert `rst_n` during EXEC/RESP → `rsp_valid`=0 and `busy`=0 immediately; the next request from req1 and req3 grants req0's successor rule from pointer 0 (req1 first).
